apb_master_ctrl: RTL and testbench

Single-outstanding APB initiator that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers. It returns read data and error status on a valid/ready response stream. It sits between a local controller (boot sequencer, test engine or CPU-less config FSM) and APB peripherals such as the GPIO block and its 6-bit register map. A programmable timeout aborts a transfer whose completer never asserts PREADY.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_wait_timer.sv | 37 +++
 rtl/apb_master_ctrl.sv | 118 +++++++++++
 tb/tb_apb_master_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, initiator FSM states and
// command/response bundles used by the initiator and its peripherals.
package apb_pkg;

    localparam int APB_ADDR_W = 6;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase. Cleared at SETUP, counts
// cycles with PREADY low, and flags expiry when the count reaches the limit
// minus one so the abort lands on the TIMEOUT_CYC-th ACCESS cycle.
module apb_wait_timer #(
    parameter int          TIMEOUT_W   = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_incr,
    output logic o_expire
);

    // Compare value; unused (and forced to zero) when the timeout is disabled.
    localparam logic [TIMEOUT_W-1:0] LIMIT =
        (TIMEOUT_CYC == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYC - 1);

    // A limit that does not fit in the counter could never be reached.
    if ((TIMEOUT_CYC >> TIMEOUT_W) != 0) begin : g_limit_check
        $error("apb_wait_timer: TIMEOUT_CYC must be below 2**TIMEOUT_W");
    end

    logic [TIMEOUT_W-1:0] r_count;

    // Saturating wait-state counter with synchronous clear.
    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_incr && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (TIMEOUT_CYC != 0) && (r_count == LIMIT);

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB initiator: accepts one command at a time, runs the
// SETUP/ACCESS handshake, and returns read data plus error/timeout status.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int          ADDR_W      = APB_ADDR_W,
    parameter int          DATA_W      = APB_DATA_W,
    parameter int          TIMEOUT_W   = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              busy
);

    apb_mst_state_e r_state;
    logic           w_timer_clear;
    logic           w_timer_incr;
    logic           w_expire;

    // Only IDLE takes commands; held low during reset so nothing is lost.
    assign cmd_ready     = (r_state == IDLE) && PRESETn;
    assign w_timer_clear = (r_state == SETUP);
    assign w_timer_incr  = (r_state == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk      (PCLK),
        .i_rst_n  (PRESETn),
        .i_clear  (w_timer_clear),
        .i_incr   (w_timer_incr),
        .o_expire (w_expire)
    );

    // Transfer FSM with all APB and response outputs registered.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_write ? cmd_wdata : '0;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    // A ready completer wins over a simultaneous timeout.
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        r_state     <= RESP;
                    end else if (w_expire) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl (TIMEOUT_CYC = 4). Stimulus pushes
// hand-computed expectations into a queue; a negedge monitor compares the
// APB phase and the response against the head of that queue.
module tb_apb_master_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [5:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        write;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          waits;     // ACCESS cycles with PREADY low before it rises
        logic [31:0] prdata;
        logic        slverr;
        int          hold;      // cycles rsp_ready stays low once rsp_valid is up
        logic        early;     // rsp_ready high before rsp_valid
        logic [31:0] exp_pwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc;   // expected number of ACCESS cycles
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[$];

    apb_master_ctrl #(
        .ADDR_W      (6),
        .DATA_W      (32),
        .TIMEOUT_W   (8),
        .TIMEOUT_CYC (4)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .busy        (busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [5:0] a, input logic [31:0] wd,
                                input int waits, input logic [31:0] prd, input logic serr,
                                input int hold, input logic early,
                                input logic [31:0] e_pwd, input logic [31:0] e_rd,
                                input logic e_err, input logic e_to, input int e_acc);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.waits = waits; v.prdata = prd;
        v.slverr = serr; v.hold = hold; v.early = early; v.exp_pwdata = e_pwd;
        v.exp_rdata = e_rd; v.exp_err = e_err; v.exp_to = e_to; v.exp_acc = e_acc;
        return v;
    endfunction

    // Monitor: checks APB phase per cycle and response against queue head.
    initial begin
        int   setup_cnt;
        int   acc_cnt;
        vec_t e;
        setup_cnt = 0;
        acc_cnt   = 0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                setup_cnt = 0;
                acc_cnt   = 0;
            end else if (PSEL || rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_activity", {30'd0, PSEL, rsp_valid}, 32'd0);
                end else begin
                    e = exp_q[0];
                    if (PSEL) begin
                        chk("paddr", {26'd0, PADDR}, {26'd0, e.addr});
                        chk("pwrite", {31'd0, PWRITE}, {31'd0, e.write});
                        chk("pwdata", PWDATA, e.exp_pwdata);
                        chk("busy_xfer", {31'd0, busy}, 32'd1);
                        if (PENABLE) acc_cnt++;
                        else         setup_cnt++;
                    end
                    if (rsp_valid) begin
                        chk("psel_in_resp", {31'd0, PSEL}, 32'd0);
                        chk("rsp_rdata", rsp_rdata, e.exp_rdata);
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.exp_err});
                        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.exp_to});
                        if (rsp_ready) begin
                            chk("setup_cycles", setup_cnt, 32'd1);
                            chk("access_cycles", acc_cnt, e.exp_acc);
                            $display("xfer %s addr=0x%02h rdata=0x%08h err=%0b timeout=%0b access=%0d",
                                     e.write ? "WR" : "RD", e.addr, rsp_rdata, rsp_err,
                                     rsp_timeout, acc_cnt);
                            void'(exp_q.pop_front());
                            setup_cnt = 0;
                            acc_cnt   = 0;
                        end
                    end
                end
            end
        end
    end

    // Issue one command, play the completer, then retire the response.
    task automatic run(input vec_t v);
        int k;
        exp_q.push_back(v);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        rsp_ready = v.early;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(posedge PCLK); #1;
            k++;
        end
        if (k >= 20) chk("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge PCLK); #1;          // accepted; DUT now in SETUP
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        @(posedge PCLK); #1;          // first ACCESS cycle
        k = 0;
        while (!rsp_valid && k < 50) begin
            PREADY  = (k >= v.waits);
            PRDATA  = v.prdata;
            PSLVERR = v.slverr;
            @(posedge PCLK); #1;
            k++;
        end
        if (k >= 50) chk("rsp_valid_timeout", 32'd0, 32'd1);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = 1'b0;
            chk("cmd_ready_stall", {31'd0, cmd_ready}, 32'd0);
            chk("busy_stall", {31'd0, busy}, 32'd1);
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", {31'd0, rsp_valid}, 32'd0);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel", {31'd0, PSEL}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_paddr", {26'd0, PADDR}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        PRESETn = 1'b1;
        #1;
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        //          wr    addr   wdata         waits prdata        serr hold early pwdata        rdata         err   to   acc
        vecs.push_back(mk(1'b1, 6'h10, 32'hFFFF0000, 0,  32'hBAD0BAD0, 1'b0, 0, 1'b0, 32'hFFFF0000, 32'h0,        1'b0, 1'b0, 1));
        vecs.push_back(mk(1'b0, 6'h14, 32'h11111111, 3,  32'h0000A5A5, 1'b0, 0, 1'b0, 32'h0,        32'h0000A5A5, 1'b0, 1'b0, 4));
        vecs.push_back(mk(1'b0, 6'h08, 32'h0,        0,  32'h12345678, 1'b1, 0, 1'b0, 32'h0,        32'h12345678, 1'b1, 1'b0, 1));
        vecs.push_back(mk(1'b0, 6'h20, 32'h0,        100, 32'hDEADBEEF, 1'b0, 0, 1'b0, 32'h0,       32'h0,        1'b1, 1'b1, 4));
        vecs.push_back(mk(1'b1, 6'h3F, 32'h87654321, 100, 32'h0,       1'b0, 0, 1'b0, 32'h87654321, 32'h0,        1'b1, 1'b1, 4));
        vecs.push_back(mk(1'b1, 6'h04, 32'h00000001, 2,  32'h0,        1'b1, 5, 1'b0, 32'h00000001, 32'h0,        1'b1, 1'b0, 3));
        vecs.push_back(mk(1'b0, 6'h00, 32'h0,        0,  32'hCAFEF00D, 1'b0, 0, 1'b1, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 1));
        foreach (vecs[i]) run(vecs[i]);

        // Reset in the middle of ACCESS: transfer dropped, no response.
        exp_q.push_back(mk(1'b0, 6'h18, 32'h0, 100, 32'h0, 1'b0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0));
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h18; cmd_wdata = 32'h0;
        @(posedge PCLK); #1;          // accepted
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("pre_rst_access", {30'd0, PSEL, PENABLE}, 32'd3);
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        chk("mid_rst_psel", {31'd0, PSEL}, 32'd0);
        chk("mid_rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        PRESETn = 1'b1;
        void'(exp_q.pop_front());
        #1;
        chk("after_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("after_rst_busy", {31'd0, busy}, 32'd0);

        run(mk(1'b0, 6'h2C, 32'h0, 1, 32'h55AA55AA, 1'b0, 0, 1'b0, 32'h0, 32'h55AA55AA, 1'b0, 1'b0, 2));

        repeat (3) @(posedge PCLK);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
